// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: ALU opcodes, instruction op codes,
// FSM state encoding, the control-word payload and small decode helpers.
package alu_sequencer_pkg;

  localparam int unsigned INSTR_W  = 8;
  localparam int unsigned OP_W     = 4;
  localparam int unsigned OPND_W   = 4;
  localparam int unsigned ALU_OP_W = 3;

  // ALU operation select driven to the datapath
  typedef enum logic [ALU_OP_W-1:0] {
    ALU_PASS_A = 3'b000,
    ALU_CMP    = 3'b001,
    ALU_PASS_B = 3'b010,
    ALU_ADD    = 3'b011,
    ALU_NAND   = 3'b100
  } alu_op_e;

  // Instruction op field, instr[7:4]
  typedef enum logic [OP_W-1:0] {
    OP_NOP   = 4'h0,
    OP_LIT   = 4'h1,
    OP_CMPI  = 4'h2,
    OP_ADDI  = 4'h3,
    OP_NANDI = 4'h4,
    OP_OUT   = 4'h5,
    OP_JMP   = 4'h6,
    OP_JC    = 4'h7,
    OP_JNC   = 4'h8,
    OP_JZ    = 4'h9,
    OP_JNZ   = 4'hA,
    OP_RSV_B = 4'hB,
    OP_RSV_C = 4'hC,
    OP_RSV_D = 4'hD,
    OP_RSV_E = 4'hE,
    OP_HALT  = 4'hF
  } op_e;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALT   = 2'd3
  } state_e;

  // Control word presented to the datapath each cycle
  typedef struct packed {
    alu_op_e             alu_opcode;
    logic [OPND_W-1:0]   alu_in;
    logic                en_accu;
    logic                en1;
    logic                en2;
  } ctrl_t;

  // Immediate ALU ops that drive the input bus and update flags
  function automatic logic is_alu_imm(input op_e op);
    return (op == OP_LIT) || (op == OP_CMPI) || (op == OP_ADDI) || (op == OP_NANDI);
  endfunction

  function automatic logic is_jump(input op_e op);
    return (op == OP_JMP) || (op == OP_JC) || (op == OP_JNC) || (op == OP_JZ) || (op == OP_JNZ);
  endfunction

  // Branch condition from the registered flags
  function automatic logic jump_taken(input op_e op, input logic c, input logic z);
    case (op)
      OP_JMP:  return 1'b1;
      OP_JC:   return c;
      OP_JNC:  return !c;
      OP_JZ:   return z;
      OP_JNZ:  return !z;
      default: return 1'b0;
    endcase
  endfunction

  function automatic alu_op_e alu_op_of(input op_e op);
    case (op)
      OP_LIT:   return ALU_PASS_B;
      OP_CMPI:  return ALU_CMP;
      OP_ADDI:  return ALU_ADD;
      OP_NANDI: return ALU_NAND;
      default:  return ALU_PASS_A;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational decode of FSM state + instruction word into the datapath
// control word.
//   state : FSM state the control word applies to
//   ir    : instruction word being executed
//   ctrl  : {alu_opcode, alu_in, en_accu, en1, en2}
module alu_seq_decode
  import alu_sequencer_pkg::*;
(
  input  state_e               state,
  input  logic [INSTR_W-1:0]   ir,
  output ctrl_t                ctrl
);

  op_e               op;
  logic [OPND_W-1:0] operand;

  assign op      = op_e'(ir[INSTR_W-1:OPND_W]);
  assign operand = ir[OPND_W-1:0];

  // Only DECODE and EXEC of ALU/OUT ops drive anything; jumps, NOP, reserved
  // ops, FETCH and HALT leave every enable low.
  always_comb begin
    ctrl = '0;
    if ((state == ST_DECODE) || (state == ST_EXEC)) begin
      if (is_alu_imm(op)) begin
        ctrl.alu_opcode = alu_op_of(op);
        ctrl.alu_in     = operand;
        ctrl.en1        = 1'b1;
        ctrl.en_accu    = (state == ST_EXEC) && (op != OP_CMPI);
      end else if ((op == OP_OUT) && (state == ST_EXEC)) begin
        ctrl.alu_opcode = ALU_PASS_A;
        ctrl.en2        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Microcoded sequencer for a 4-bit accumulator ALU: fetches 8-bit program
// words from a combinational ROM and drives the datapath control lines.
//   clk, rst          : clock, asynchronous active-low reset
//   run               : permits new fetches
//   instr             : ROM word at pc ([7:4] op, [3:0] operand)
//   carry, zero       : datapath flags, captured at the end of ALU ops
//   pc                : program address
//   alu_opcode/alu_in : ALU select and operand bus
//   en_accu/en1/en2   : accumulator load, input-bus and output-bus enables
//   halted            : set once HALT executes, cleared only by reset
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int unsigned PROG_AW = 4
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [INSTR_W-1:0]   instr,
  input  logic                 carry,
  input  logic                 zero,
  output logic [PROG_AW-1:0]   pc,
  output logic [ALU_OP_W-1:0]  alu_opcode,
  output logic [OPND_W-1:0]    alu_in,
  output logic                 en_accu,
  output logic                 en1,
  output logic                 en2,
  output logic                 halted
);

  state_e               state_q, state_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic [PROG_AW-1:0]   pc_q, pc_d;
  logic                 flag_c_q, flag_c_d;
  logic                 flag_z_q, flag_z_d;
  ctrl_t                ctrl_q, ctrl_d;
  logic                 halted_q;
  op_e                  op;

  assign op = op_e'(ir_q[INSTR_W-1:OPND_W]);

  // Next-state, IR, PC and flag update
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    pc_d     = pc_q;
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    case (state_q)
      ST_FETCH: begin
        if (run) begin
          ir_d    = instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (op == OP_HALT) begin
          state_d = ST_HALT;
        end else if (is_jump(op)) begin
          pc_d    = jump_taken(op, flag_c_q, flag_z_q) ? PROG_AW'(ir_q[OPND_W-1:0])
                                                       : pc_q + PROG_AW'(1);
          state_d = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        pc_d    = pc_q + PROG_AW'(1);
        state_d = ST_FETCH;
        if (is_alu_imm(op)) begin
          flag_c_d = carry;
          flag_z_d = zero;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  // Decode against the upcoming state/IR so the control flops line up with
  // the cycle they belong to while staying fully registered.
  alu_seq_decode u_decode (
    .state (state_d),
    .ir    (ir_d),
    .ctrl  (ctrl_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_FETCH;
      ir_q     <= '0;
      pc_q     <= '0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
      ctrl_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      pc_q     <= pc_d;
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
      ctrl_q   <= ctrl_d;
      halted_q <= (state_d == ST_HALT);
    end
  end

  assign pc         = pc_q;
  assign alu_opcode = ctrl_q.alu_opcode;
  assign alu_in     = ctrl_q.alu_in;
  assign en_accu    = ctrl_q.en_accu;
  assign en1        = ctrl_q.en1;
  assign en2        = ctrl_q.en2;
  assign halted     = halted_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: ROM + reference ALU/accumulator around the DUT,
// per-cycle expected output vectors queued and compared on the falling edge.
module tb_alu_sequencer;

  logic       clk, rst, run;
  logic [7:0] instr;
  logic       carry, zero;
  logic [3:0] pc;
  logic [2:0] alu_opcode;
  logic [3:0] alu_in;
  logic       en_accu, en1, en2, halted;

  logic [7:0]  rom [16];
  logic [3:0]  acc;
  logic [4:0]  alu_res;
  logic [14:0] exp_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  alu_sequencer #(.PROG_AW(4)) dut (
    .clk(clk), .rst(rst), .run(run), .instr(instr), .carry(carry), .zero(zero),
    .pc(pc), .alu_opcode(alu_opcode), .alu_in(alu_in), .en_accu(en_accu),
    .en1(en1), .en2(en2), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign instr = rom[pc];

  // Reference ALU: bit 4 is carry (borrow for compare)
  always_comb begin
    case (alu_opcode)
      3'b000:  alu_res = {1'b0, acc};
      3'b001:  alu_res = {1'b0, acc} - {1'b0, alu_in};
      3'b010:  alu_res = {1'b0, alu_in};
      3'b011:  alu_res = {1'b0, acc} + {1'b0, alu_in};
      3'b100:  alu_res = {1'b0, ~(acc & alu_in)};
      default: alu_res = 5'h00;
    endcase
  end
  assign carry = alu_res[4];
  assign zero  = (alu_res[3:0] == 4'h0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         acc <= 4'h0;
    else if (en_accu) acc <= alu_res[3:0];
  end

  // Expected vector {pc, alu_opcode, alu_in, en_accu, en1, en2, halted}
  function automatic logic [14:0] ev(input logic [3:0] p, input logic [2:0] o, input logic [3:0] a,
                                     input logic ea, input logic e1, input logic e2, input logic h);
    return {p, o, a, ea, e1, e2, h};
  endfunction

  function automatic logic [14:0] obs();
    return {pc, alu_opcode, alu_in, en_accu, en1, en2, halted};
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    run = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [14:0] e;
    do_reset();
    #1;
    n_checks++;
    if (obs() !== ev(4'h0, 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
      n_fail++; $display("FAIL reset_idle: got %h expected %h", obs(), ev(4'h0, 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    rom[1] = 8'h35;
    rst = 1'b1; run = 1'b1;
    exp_q.push_back(ev(4'h0, 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(4'h0, 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(4'h0, 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(4'h1, 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(4'h1, 3'b011, 4'h5, 1'b0, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(ev(4'h1, 3'b011, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0));
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL reset_pre c%0d: got %h expected %h", k, obs(), e); end
    end
    // Reset asserted in the middle of ADDI's EXEC cycle
    rst = 1'b0;
    #1;
    n_checks++;
    if (obs() !== ev(4'h0, 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
      n_fail++; $display("FAIL reset_mid_exec: got %h expected %h", obs(), ev(4'h0, 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    rom[0] = 8'h13;
    @(negedge clk);
    rst = 1'b1;
    exp_q.push_back(ev(4'h0, 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(4'h0, 3'b010, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0));
    for (int k = 1; k <= 2; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL reset_first_fetch c%0d: got %h expected %h", k, obs(), e); end
    end
  endtask

  // LIT 7, ADDI 9, then each jump op to 0xC with flags C=1 Z=1
  task automatic test_alu_program();
    logic [14:0] e;
    logic [7:0]  jop [5];
    logic [3:0]  jpc [5];
    jop = '{8'h6C, 8'h7C, 8'h8C, 8'h9C, 8'hAC};
    jpc = '{4'hC, 4'hC, 4'h3, 4'hC, 4'h3};
    for (int j = 0; j < 5; j++) begin
      do_reset();
      rom[0] = 8'h17; rom[1] = 8'h39; rom[2] = jop[j];
      rst = 1'b1; run = 1'b1;
      exp_q.push_back(ev(4'h0, 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(ev(4'h0, 3'b010, 4'h7, 1'b0, 1'b1, 1'b0, 1'b0));
      exp_q.push_back(ev(4'h0, 3'b010, 4'h7, 1'b1, 1'b1, 1'b0, 1'b0));
      exp_q.push_back(ev(4'h1, 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(ev(4'h1, 3'b011, 4'h9, 1'b0, 1'b1, 1'b0, 1'b0));
      exp_q.push_back(ev(4'h1, 3'b011, 4'h9, 1'b1, 1'b1, 1'b0, 1'b0));
      exp_q.push_back(ev(4'h2, 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(ev(4'h2, 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(ev(jpc[j], 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
      for (int k = 1; k <= 9; k++) begin
        if (k > 1) @(negedge clk);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL prog op%h c%0d: got %h expected %h", jop[j], k, obs(), e); end
        if (k == 4) begin
          n_checks++;
          if (acc !== 4'h7) begin n_fail++; $display("FAIL prog_acc_lit: got %h expected 7", acc); end
        end
        if (k == 7) begin
          n_checks++;
          if (acc !== 4'h0) begin n_fail++; $display("FAIL prog_acc_add: got %h expected 0", acc); end
        end
      end
    end
  endtask

  // Conditional jumps with flags still 00 from reset
  task automatic test_jump_reset_flags();
    logic [14:0] e;
    logic [7:0]  jop [4];
    logic [3:0]  jpc [4];
    jop = '{8'h75, 8'h85, 8'h95, 8'hA5};
    jpc = '{4'h1, 4'h5, 4'h1, 4'h5};
    for (int j = 0; j < 4; j++) begin
      do_reset();
      rom[0] = jop[j];
      rst = 1'b1; run = 1'b1;
      exp_q.push_back(ev(4'h0, 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(ev(4'h0, 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(ev(jpc[j], 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
      for (int k = 1; k <= 3; k++) begin
        if (k > 1) @(negedge clk);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL jump00 op%h c%0d: got %h expected %h", jop[j], k, obs(), e); end
      end
    end
  endtask

  // LIT 7, CMPI 7 (no load, Z=1), JZ 9, NANDI C, reserved op 0xB
  task automatic test_cmp_nand();
    logic [14:0] e;
    do_reset();
    rom[0] = 8'h17; rom[1] = 8'h27; rom[2] = 8'h99; rom[9] = 8'h4C; rom[10] = 8'hB3;
    rst = 1'b1; run = 1'b1;
    exp_q.push_back(ev(4'h0, 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(4'h0, 3'b010, 4'h7, 1'b0, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(ev(4'h0, 3'b010, 4'h7, 1'b1, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(ev(4'h1, 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(4'h1, 3'b001, 4'h7, 1'b0, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(ev(4'h1, 3'b001, 4'h7, 1'b0, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(ev(4'h2, 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(4'h2, 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(4'h9, 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(4'h9, 3'b100, 4'hC, 1'b0, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(ev(4'h9, 3'b100, 4'hC, 1'b1, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(ev(4'hA, 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(4'hA, 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(4'hA, 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(4'hB, 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int k = 1; k <= 15; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL cmp_nand c%0d: got %h expected %h", k, obs(), e); end
      if (k == 7) begin
        n_checks++;
        if (acc !== 4'h7) begin n_fail++; $display("FAIL cmp_acc: got %h expected 7", acc); end
      end
      if (k == 12) begin
        n_checks++;
        if (acc !== 4'hB) begin n_fail++; $display("FAIL nand_acc: got %h expected b", acc); end
      end
    end
  endtask

  // All NOP: pc advances every 3 cycles and wraps 15 -> 0
  task automatic test_nop_wrap();
    logic [14:0] e;
    do_reset();
    rst = 1'b1; run = 1'b1;
    for (int k = 1; k <= 50; k++)
      exp_q.push_back(ev(4'(((k - 1) / 3) % 16), 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int k = 1; k <= 50; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL nop_wrap c%0d: got %h expected %h", k, obs(), e); end
    end
  endtask

  // OUT at 0, LIT A at 15: run once around the ROM back to OUT
  task automatic test_out();
    logic [14:0] e;
    logic [3:0]  a;
    do_reset();
    rom[0] = 8'h50; rom[15] = 8'h1A;
    rst = 1'b1; run = 1'b1;
    for (int n = 0; n <= 16; n++) begin
      a = 4'(n % 16);
      exp_q.push_back(ev(a, 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
      if (a == 4'h0) begin
        exp_q.push_back(ev(a, 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(ev(a, 3'b000, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0));
      end else if (a == 4'hF) begin
        exp_q.push_back(ev(a, 3'b010, 4'hA, 1'b0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(ev(a, 3'b010, 4'hA, 1'b1, 1'b1, 1'b0, 1'b0));
      end else begin
        exp_q.push_back(ev(a, 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(ev(a, 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
      end
    end
    for (int k = 1; k <= 51; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL out c%0d: got %h expected %h", k, obs(), e); end
    end
    n_checks++;
    if (acc !== 4'hA) begin n_fail++; $display("FAIL out_bus_data: got %h expected a", acc); end
  endtask

  // HALT at address 3 holds pc and enables regardless of run
  task automatic test_halt();
    logic [14:0] e;
    do_reset();
    rom[0] = 8'h11; rom[3] = 8'hF0;
    rst = 1'b1; run = 1'b1;
    exp_q.push_back(ev(4'h0, 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(4'h0, 3'b010, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(ev(4'h0, 3'b010, 4'h1, 1'b1, 1'b1, 1'b0, 1'b0));
    for (int k = 4; k <= 11; k++)
      exp_q.push_back(ev(4'((k - 1) / 3), 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int k = 12; k <= 31; k++)
      exp_q.push_back(ev(4'h3, 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1));
    for (int k = 1; k <= 31; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL halt c%0d: got %h expected %h", k, obs(), e); end
      if (k >= 12) run = ~run;
    end
  endtask

  // run dropped during DECODE: LIT completes, FSM parks in FETCH, then resumes
  task automatic test_run_stop();
    logic [14:0] e;
    do_reset();
    rom[0] = 8'h14; rom[1] = 8'h12;
    rst = 1'b1; run = 1'b1;
    exp_q.push_back(ev(4'h0, 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(4'h0, 3'b010, 4'h4, 1'b0, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(ev(4'h0, 3'b010, 4'h4, 1'b1, 1'b1, 1'b0, 1'b0));
    for (int k = 4; k <= 10; k++)
      exp_q.push_back(ev(4'h1, 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(4'h1, 3'b010, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0));
    for (int k = 1; k <= 11; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL run_stop c%0d: got %h expected %h", k, obs(), e); end
      if (k == 2)  run = 1'b0;
      if (k == 10) run = 1'b1;
      if (k == 4) begin
        n_checks++;
        if (acc !== 4'h4) begin n_fail++; $display("FAIL run_stop_acc: got %h expected 4", acc); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    run = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    test_reset();
    test_alu_program();
    test_jump_reset_flags();
    test_cmp_nand();
    test_nop_wrap();
    test_out();
    test_halt();
    test_run_stop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
